// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-addressed load/store unit in front of a word-only Data_RAM
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   i_req_valid / o_req_ready   request handshake; ready only while idle
//   i_op, i_addr, i_wdata       operation, byte address, right-aligned store data
//   o_resp_valid                one-cycle completion pulse
//   o_rdata                     extended load result (0 for stores / misaligned)
//   o_misaligned                qualifies o_resp_valid
//   o_ram_addr                  word address to Data_RAM
//   o_ram_wdata, o_ram_wen      Data_RAM write port
//   i_ram_rdata                 Data_RAM combinational read data
module mem_access_unit #(
    parameter int RAM_AW     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_op,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    output logic              o_ram_wen,
    input  logic [31:0]       i_ram_rdata
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic        mis_q;

    logic        req_mis;
    logic        is_store_q;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Halfword accesses need addr[0]=0, word accesses addr[1:0]=0.
    always_comb begin
        req_mis = 1'b0;
        case (i_op)
            OP_LH, OP_LHU, OP_SH: req_mis = i_addr[0];
            OP_LW, OP_SW:         req_mis = |i_addr[1:0];
            default:              req_mis = 1'b0;
        endcase
    end

    assign is_store_q = (op_q == OP_SW) || (op_q == OP_SB) || (op_q == OP_SH);

    // Bit offsets of the addressed byte / halfword lane inside the RAM word.
    assign byte_sh  = {(BIG_ENDIAN ? ~addr_lo_q : addr_lo_q), 3'b000};
    assign half_sh  = {(BIG_ENDIAN ? ~addr_lo_q[1] : addr_lo_q[1]), 4'b0000};
    assign byte_val = 8'(i_ram_rdata >> byte_sh);
    assign half_val = 16'(i_ram_rdata >> half_sh);

    always_comb begin
        load_val = 32'd0;
        case (op_q)
            OP_LB:   load_val = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  load_val = {24'd0, byte_val};
            OP_LH:   load_val = {{16{half_val[15]}}, half_val};
            OP_LHU:  load_val = {16'd0, half_val};
            OP_LW:   load_val = i_ram_rdata;
            default: load_val = 32'd0;
        endcase
    end

    // Sub-word store: keep the other lanes of the current RAM word.
    always_comb begin
        merge_val = i_ram_rdata;
        if (op_q == OP_SB)
            merge_val = (i_ram_rdata & ~(32'h0000_00FF << byte_sh))
                      | ({24'd0, wdata_q[7:0]} << byte_sh);
        else if (op_q == OP_SH)
            merge_val = (i_ram_rdata & ~(32'h0000_FFFF << half_sh))
                      | ({16'd0, wdata_q[15:0]} << half_sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_misaligned = 1'b0;
        o_ram_wen    = 1'b0;
        o_ram_wdata  = 32'd0;
        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_d = req_mis ? RESP : ACCESS;
            end
            ACCESS: begin
                if (op_q == OP_SW) begin
                    o_ram_wen   = 1'b1;
                    o_ram_wdata = wdata_q;
                end
                state_d = ((op_q == OP_SB) || (op_q == OP_SH)) ? WRITE : RESP;
            end
            WRITE: begin
                o_ram_wen   = 1'b1;
                o_ram_wdata = merged_q;
                state_d     = RESP;
            end
            RESP: begin
                o_resp_valid = 1'b1;
                o_misaligned = mis_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_LB;
            addr_lo_q  <= 2'd0;
            wdata_q    <= 32'd0;
            merged_q   <= 32'd0;
            mis_q      <= 1'b0;
            o_rdata    <= 32'd0;
            o_ram_addr <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        op_q      <= i_op;
                        addr_lo_q <= i_addr[1:0];
                        wdata_q   <= i_wdata;
                        mis_q     <= req_mis;
                        if (req_mis) o_rdata <= 32'd0;
                        else         o_ram_addr <= RAM_AW'(i_addr[31:2]);
                    end
                end
                ACCESS: begin
                    if (!is_store_q)        o_rdata  <= load_val;
                    else if (op_q == OP_SW) o_rdata  <= 32'd0;
                    else                    merged_q <= merge_val;
                end
                WRITE: o_rdata <= 32'd0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_op;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_resp_valid;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic [31:0] o_ram_addr;
    logic [31:0] o_ram_wdata;
    logic        o_ram_wen;
    logic [31:0] i_ram_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];
    logic        init;

    always #5 clk = ~clk;

    assign i_ram_rdata = mem[o_ram_addr[5:0]];

    always @(posedge clk) begin
        if (init) begin
            mem[0]  <= 32'h0000_0000;
            mem[1]  <= 32'hCAFE_0001;
            mem[53] <= 32'h8899_AABB;
        end else if (o_ram_wen) begin
            mem[o_ram_addr[5:0]] <= o_ram_wdata;
        end
    end

    mem_access_unit #(.RAM_AW(32), .BIG_ENDIAN(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_op         (i_op),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_resp_valid (o_resp_valid),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .o_ram_wen    (o_ram_wen),
        .i_ram_rdata  (i_ram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_mis,
                          input int exp_wen, input logic [31:0] exp_wdata);
        int          lat;
        int          wen_cnt;
        logic [31:0] seen_wdata;
        wen_cnt    = 0;
        seen_wdata = 32'd0;
        i_op        = op;
        i_addr      = addr;
        i_wdata     = wdata;
        i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        lat = 1;
        if (!exp_mis) check({tag, " ram_addr"}, o_ram_addr, {2'b00, addr[31:2]});
        while (o_resp_valid !== 1'b1 && lat < 8) begin
            if (o_ram_wen === 1'b1) begin
                wen_cnt++;
                seen_wdata = o_ram_wdata;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (o_ram_wen === 1'b1) wen_cnt++;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, o_rdata, exp_rdata);
        check({tag, " misaligned"}, {31'd0, o_misaligned}, {31'd0, exp_mis});
        check({tag, " wen_cycles"}, 32'(wen_cnt), 32'(exp_wen));
        if (exp_wen > 0) check({tag, " ram_wdata"}, seen_wdata, exp_wdata);
        @(posedge clk); #1;
    endtask

    logic [2:0]  b_op    [3];
    logic [31:0] b_addr  [3];
    logic [31:0] b_wdata [3];
    int          acc_cyc [3];
    logic [31:0] resp_rd [3];

    initial begin
        int   resp_cnt;
        int   wen_cnt;
        int   cyc;
        int   idx;
        int   nresp;
        logic acc;

        rst_n       = 1'b0;
        init        = 1'b1;
        i_req_valid = 1'b0;
        i_op        = 3'b000;
        i_addr      = 32'd0;
        i_wdata     = 32'd0;
        #1;
        check("reset req_ready", {31'd0, o_req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, o_resp_valid}, 32'd0);
        check("reset misaligned", {31'd0, o_misaligned}, 32'd0);
        check("reset ram_wen", {31'd0, o_ram_wen}, 32'd0);
        check("reset rdata", o_rdata, 32'd0);
        check("reset ram_addr", o_ram_addr, 32'd0);
        check("reset ram_wdata", o_ram_wdata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        init  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req("LB215",  3'b000, 32'd215, 32'd0, 2, 32'hFFFF_FF88, 1'b0, 0, 32'd0);
        do_req("LBU215", 3'b100, 32'd215, 32'd0, 2, 32'h0000_0088, 1'b0, 0, 32'd0);
        do_req("LHU212", 3'b101, 32'd212, 32'd0, 2, 32'h0000_AABB, 1'b0, 0, 32'd0);
        do_req("LH214",  3'b001, 32'd214, 32'd0, 2, 32'hFFFF_8899, 1'b0, 0, 32'd0);
        do_req("LW212",  3'b010, 32'd212, 32'd0, 2, 32'h8899_AABB, 1'b0, 0, 32'd0);
        do_req("SH214",  3'b111, 32'd214, 32'h0000_1234, 3, 32'd0, 1'b0, 1, 32'h1234_AABB);
        do_req("LW212b", 3'b010, 32'd212, 32'd0, 2, 32'h1234_AABB, 1'b0, 0, 32'd0);
        do_req("LW213",  3'b010, 32'd213, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0);
        do_req("SH215",  3'b111, 32'd215, 32'h0000_5678, 1, 32'd0, 1'b1, 0, 32'd0);
        do_req("LB212",  3'b000, 32'd212, 32'd0, 2, 32'hFFFF_FFBB, 1'b0, 0, 32'd0);

        // SB abandoned by a reset pulse while in ACCESS
        i_op        = 3'b110;
        i_addr      = 32'd212;
        i_wdata     = 32'h0000_0055;
        i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid req_ready", {31'd0, o_req_ready}, 32'd1);
        check("rst_mid ram_wen", {31'd0, o_ram_wen}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_release req_ready", {31'd0, o_req_ready}, 32'd1);
        resp_cnt = 0;
        wen_cnt  = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (o_resp_valid === 1'b1) resp_cnt++;
            if (o_ram_wen === 1'b1) wen_cnt++;
        end
        check("rst_mid resp_count", 32'(resp_cnt), 32'd0);
        check("rst_mid wen_count", 32'(wen_cnt), 32'd0);
        check("rst_mid word53", mem[53], 32'h1234_AABB);

        // Back-to-back with i_req_valid held high
        b_op[0] = 3'b011; b_addr[0] = 32'd0; b_wdata[0] = 32'd127;
        b_op[1] = 3'b010; b_addr[1] = 32'd0; b_wdata[1] = 32'd0;
        b_op[2] = 3'b010; b_addr[2] = 32'd4; b_wdata[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = -1;
            resp_rd[i] = 32'hDEAD_DEAD;
        end
        idx   = 0;
        nresp = 0;
        cyc   = 0;
        i_op        = b_op[0];
        i_addr      = b_addr[0];
        i_wdata     = b_wdata[0];
        i_req_valid = 1'b1;
        while (nresp < 3 && cyc < 40) begin
            acc = i_req_valid && o_req_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    i_op    = b_op[idx];
                    i_addr  = b_addr[idx];
                    i_wdata = b_wdata[idx];
                end else begin
                    i_req_valid = 1'b0;
                end
            end
            if (o_resp_valid === 1'b1) begin
                resp_rd[nresp] = o_rdata;
                nresp++;
            end
        end
        i_req_valid = 1'b0;
        check("b2b resp_count", 32'(nresp), 32'd3);
        check("b2b accept0", 32'(acc_cyc[0]), 32'd1);
        check("b2b accept1", 32'(acc_cyc[1]), 32'd4);
        check("b2b accept2", 32'(acc_cyc[2]), 32'd7);
        check("b2b resp0 SW", resp_rd[0], 32'd0);
        check("b2b resp1 LW0", resp_rd[1], 32'd127);
        check("b2b resp2 LW4", resp_rd[2], 32'hCAFE_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit sitting directly upstream of Data_RAM; converts CPU byte-addressed load/store requests into word accesses on the RAM port.
- Handles byte/halfword extraction with sign/zero extension on loads, and read-modify-write for sub-word stores because Data_RAM writes whole words only.
- Flags misaligned accesses without touching RAM.
- Data_RAM interface is fixed: word-indexed address, combinational read data, write on rising clk when write enable is high.

Parameters:
- RAM_AW, 32, width of word address driven to Data_RAM.
- BIG_ENDIAN, 0, byte lane order: 0 means byte 0 is bits [7:0]; 1 means byte 0 is bits [31:24].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  unit can accept; high only in IDLE.
- i_op  in  3  000 LB, 001 LH, 010 LW, 011 SW, 100 LBU, 101 LHU, 110 SB, 111 SH.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned for SB/SH.
- o_resp_valid  out  1  one-cycle completion pulse.
- o_rdata  out  32  load result, extended; 0 for stores and misaligned accesses.
- o_misaligned  out  1  qualifies o_resp_valid.
- o_ram_addr  out  RAM_AW  word address to Data_RAM, i_addr[31:2] zero-extended or truncated.
- o_ram_wdata  out  32  word written to Data_RAM.
- o_ram_wen  out  1  Data_RAM write enable.
- i_ram_rdata  in  32  Data_RAM combinational read data.

Behaviour:
- Reset (async, immediate): state IDLE; o_req_ready=1; o_resp_valid, o_misaligned, o_ram_wen=0; o_rdata, o_ram_addr, o_ram_wdata=0.
- Accept on the rising edge with i_req_valid && o_req_ready. At that edge, latch op, addr and wdata. Inputs are ignored at all other times.
- FSM states: IDLE, ACCESS, WRITE, RESP.
  - IDLE -> RESP if the request is misaligned. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - IDLE -> ACCESS for all other requests.
  - ACCESS, loads: sample i_ram_rdata, select the lane, extend (LB/LH sign, LBU/LHU zero), register into o_rdata; -> RESP.
  - ACCESS, SW: o_ram_wen=1, o_ram_wdata=latched wdata; -> RESP.
  - ACCESS, SB/SH: sample i_ram_rdata, merge the new byte/halfword into the addressed lane and register the merged word; -> WRITE.
  - WRITE: o_ram_wen=1, o_ram_wdata=merged word; -> RESP.
  - RESP: o_resp_valid=1 for exactly one cycle; o_misaligned valid; -> IDLE.
- Latency from accept edge to o_resp_valid high: misaligned 1 cycle; loads and SW 2 cycles; SB/SH 3 cycles.
- Back-to-back: the next accept occurs no earlier than the edge ending RESP.
- o_ram_addr updates on the accept edge (aligned requests only) and holds through RESP.
- o_ram_wen is high in at most one cycle per request and never for loads or misaligned requests.
- o_rdata holds its value until the next load response; it is cleared on store and misaligned responses.
- Lane select uses addr[1:0] and BIG_ENDIAN. Halfword lanes are addr[1]=0 and addr[1]=1.
- Reset mid-operation: state returns to IDLE immediately. A pending RMW write is abandoned with no partial write, and no response is issued.

Test Plan:
- RAM word 53 = 0x8899AABB, BIG_ENDIAN=0, LB at addr 215 -> o_ram_addr=53; o_rdata=0xFFFFFF88 two cycles after accept; o_misaligned=0.
- Same preload: LBU 215 -> 0x00000088; LHU 212 -> 0x0000AABB; LH 214 -> 0xFFFF8899; LW 212 -> 0x8899AABB.
- SH at 214 with i_wdata=0x00001234 -> o_ram_wen high for exactly one cycle (WRITE) with o_ram_wdata=0x1234AABB; response 3 cycles after accept; a subsequent LW 212 returns 0x1234AABB.
- LW at 213 and SH at 215 -> o_resp_valid with o_misaligned=1 one cycle after accept; o_rdata=0; o_ram_wen never asserted.
- SB at 212 with rst_n pulsed low during ACCESS -> no o_ram_wen and no o_resp_valid; word 53 is unchanged; o_req_ready=1 right after reset release.
- i_req_valid held high over SW 0 (data 127), LW 0, LW 4 -> accepts spaced 3 cycles apart; responses in order; first LW returns 127.
